// File: rtl/mux_step_ctrl_pkg.sv
// Shared types and defaults for the design-mux step controller.
// Imported by the register block and the sequencing FSM.
package mux_step_ctrl_pkg;

    localparam int RST_LEN_DEF = 8;
    localparam int NDESIGN     = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_ASSERT,
        ST_SWITCH,
        ST_RST_HOLD,
        ST_STEP_HI,
        ST_STEP_LO
    } state_t;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_RSTLEN = 2'd1,
        REG_STEP   = 2'd2,
        REG_STATUS = 2'd3
    } reg_off_t;

    // A zero hold length still holds reset for one cycle.
    function automatic logic [7:0] hold_len(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/mux_wb_regs.sv
// Wishbone slave for the step controller: decode, single-cycle ack,
// register file, sticky error flag and command pulses to the FSM.
module mux_wb_regs
    import mux_step_ctrl_pkg::*;
#(
    parameter int RST_LEN_INIT = 8,
    parameter int NUM_DESIGN   = 13
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic        busy,
    input  logic [2:0]  state_code,
    input  logic [15:0] count,
    input  logic [3:0]  design_addr,
    output logic        start_switch,
    output logic        start_step,
    output logic        abort_req,
    output logic [3:0]  target,
    output logic [15:0] step_n,
    output logic [7:0]  rst_len,
    output logic        err
);

    localparam logic [4:0] NDES5 = 5'(NUM_DESIGN);

    logic        xfer;
    logic        wr;
    logic [1:0]  sel;
    logic        ctrl_wr;
    logic        step_wr;
    logic        go;
    logic        tgt_bad;
    logic        err_set;
    logic        err_clr;
    logic [31:0] rdata;
    logic        unused;

    // Ack drops for a cycle between back-to-back strobes.
    assign xfer = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr   = xfer & wbs_we_i;
    assign sel  = wbs_adr_i[3:2];

    assign ctrl_wr = wr && (reg_off_t'(sel) == REG_CTRL);
    assign step_wr = wr && (reg_off_t'(sel) == REG_STEP);
    assign go      = ctrl_wr & wbs_dat_i[4];
    assign tgt_bad = {1'b0, wbs_dat_i[3:0]} >= NDES5;

    assign target       = wbs_dat_i[3:0];
    assign step_n       = wbs_dat_i[15:0];
    assign start_switch = go & ~busy & ~tgt_bad;
    assign start_step   = step_wr & ~busy & (step_n != 16'd0);
    assign abort_req    = ctrl_wr & wbs_dat_i[5];

    assign err_set = (go & (busy | tgt_bad)) | (step_wr & busy);
    assign err_clr = ctrl_wr & wbs_dat_i[6];

    assign unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16]};

    always_comb begin
        rdata = '0;
        unique case (reg_off_t'(sel))
            REG_CTRL:   rdata = {25'b0, err, 2'b0, design_addr};
            REG_RSTLEN: rdata = {24'b0, rst_len};
            REG_STEP:   rdata = {16'b0, count};
            REG_STATUS: rdata = {20'b0, err, busy, state_code,
                                 (count != 16'd0), 2'b00, design_addr};
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            rst_len   <= 8'(RST_LEN_INIT);
            err       <= 1'b0;
        end else begin
            wbs_ack_o <= xfer;
            if (xfer && !wbs_we_i)
                wbs_dat_o <= rdata;
            if (wr && (reg_off_t'(sel) == REG_RSTLEN))
                rst_len <= wbs_dat_i[7:0];
            err <= (err & ~err_clr) | err_set;
        end
    end

endmodule

// File: rtl/mux_step_ctrl.sv
// Design-mux controller: reset/switch sequencing and single-step
// clock generation, driven from the Wishbone register block.
module mux_step_ctrl #(
    parameter int RST_LEN_DEF = mux_step_ctrl_pkg::RST_LEN_DEF,
    parameter int NDESIGN     = mux_step_ctrl_pkg::NDESIGN
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [3:0]  design_addr_o,
    output logic        design_rst_o,
    output logic        step_clk_o,
    output logic        busy_o
);

    import mux_step_ctrl_pkg::*;

    state_t      state;
    logic [3:0]  tgt;
    logic [15:0] count;
    logic [7:0]  hold;
    logic        abort_q;

    logic        start_switch;
    logic        start_step;
    logic        abort_req;
    logic [3:0]  target;
    logic [15:0] step_n;
    logic [7:0]  rst_len;
    logic        err;
    logic [2:0]  state_code;

    assign busy_o     = (state != ST_IDLE);
    assign state_code = state;

    mux_wb_regs #(
        .RST_LEN_INIT (RST_LEN_DEF),
        .NUM_DESIGN   (NDESIGN)
    ) u_regs (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_n     (wb_rst_n),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_dat_o    (wbs_dat_o),
        .wbs_ack_o    (wbs_ack_o),
        .busy         (busy_o),
        .state_code   (state_code),
        .count        (count),
        .design_addr  (design_addr_o),
        .start_switch (start_switch),
        .start_step   (start_step),
        .abort_req    (abort_req),
        .target       (target),
        .step_n       (step_n),
        .rst_len      (rst_len),
        .err          (err)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state         <= ST_IDLE;
            design_addr_o <= '0;
            design_rst_o  <= 1'b1;
            step_clk_o    <= 1'b0;
            count         <= '0;
            hold          <= '0;
            tgt           <= '0;
            abort_q       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    if (start_switch) begin
                        tgt          <= target;
                        design_rst_o <= 1'b1;
                        state        <= ST_RST_ASSERT;
                    end else if (start_step) begin
                        count      <= step_n;
                        step_clk_o <= 1'b1;
                        state      <= ST_STEP_HI;
                    end
                end
                ST_RST_ASSERT: state <= ST_SWITCH;
                ST_SWITCH: begin
                    design_addr_o <= tgt;
                    hold          <= hold_len(rst_len);
                    state         <= ST_RST_HOLD;
                end
                ST_RST_HOLD: begin
                    if (hold <= 8'd1) begin
                        design_rst_o <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        hold <= hold - 8'd1;
                    end
                end
                // An abort seen while high is held until the low phase ends.
                ST_STEP_HI: begin
                    step_clk_o <= 1'b0;
                    state      <= ST_STEP_LO;
                    if (abort_req)
                        abort_q <= 1'b1;
                end
                ST_STEP_LO: begin
                    if (abort_req || abort_q) begin
                        count <= '0;
                        state <= ST_IDLE;
                    end else if (count <= 16'd1) begin
                        count <= '0;
                        state <= ST_IDLE;
                    end else begin
                        count      <= count - 16'd1;
                        step_clk_o <= 1'b1;
                        state      <= ST_STEP_HI;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
